fifo_read_drainer: RTL and testbench

Read-side consumer for the asynchronous FIFO, in the `Rclk` domain. It issues `Pop` whenever the FIFO is non-empty and there is buffer room. It captures the FIFO's registered read data into a 2-entry output buffer and presents it downstream on a valid/ready stream. It also counts delivered words and supports enable/flush control. It replaces ad-hoc testbench popping with a synthesizable reader.

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/rd_skid_buf.sv | 57 +++++
 rtl/fifo_read_drainer.sv | 97 +++++++++
 tb/tb_fifo_read_drainer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-side drainer.
// The output buffer depth is fixed at two; pointer and occupancy widths follow from it.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } rd_state_t;

    localparam int RD_BUF_DEPTH   = 2;
    localparam int RD_PTR_W       = 1;
    localparam int RD_OCC_W       = 2;
    localparam int RD_COUNT_WIDTH = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer: tail written by captured FIFO words, head drained downstream.
// Flush empties the buffer and suppresses any write in the same cycle.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DataSize = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [DataSize-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  logic                flush_i,
    output logic [DataSize-1:0] rd_data_o,
    output logic [RD_OCC_W-1:0] occ_o,
    output logic [RD_OCC_W-1:0] occ_next_o
);

    logic [DataSize-1:0] mem_q [RD_BUF_DEPTH];
    logic [RD_PTR_W-1:0] head_q, head_d;
    logic [RD_PTR_W-1:0] tail_q, tail_d;
    logic [RD_OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (wr_en_i) tail_d = tail_q + 1'b1;
            if (rd_en_i) head_d = head_q + 1'b1;
            occ_d = occ_q + RD_OCC_W'(wr_en_i) - RD_OCC_W'(rd_en_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (wr_en_i && !flush_i) mem_q[tail_q] <= wr_data_i;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign rd_data_o  = mem_q[head_q];
    assign occ_o      = occ_q;
    assign occ_next_o = occ_d;

endmodule

// File: rtl/fifo_read_drainer.sv
// Read-domain FIFO consumer: pops while there is room, buffers two words, streams them out.
// state | meaning
// IDLE  | nothing held or in flight, Enable low
// RUN   | popping allowed
// STALL | held plus in-flight words fill the buffer
// DRAIN | Enable low, finishing held and in-flight words
module fifo_read_drainer
    import fifo_rd_pkg::*;
#(
    parameter int DataSize   = 8,
    parameter int CountWidth = RD_COUNT_WIDTH
) (
    input  logic                  Rclk,
    input  logic                  Rreset,
    input  logic                  Enable,
    input  logic                  Flush,
    input  logic                  empty,
    input  logic [DataSize-1:0]   FifoData,
    output logic                  Pop,
    output logic [DataSize-1:0]   OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [CountWidth-1:0] WordCount,
    output logic                  Busy
);

    rd_state_t             state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [RD_OCC_W-1:0]   occ, occ_next;
    logic [2:0]            committed;
    logic                  xfer;
    logic                  held_next;
    logic                  full_next;

    assign OutValid  = (occ != '0) & ~Flush;
    assign xfer      = OutValid & OutReady;
    assign committed = 3'(occ) + 3'(inflight_q);
    // A transfer this cycle frees a slot, so it is credited before the room check.
    assign Pop       = Enable & ~empty & ~Flush & ~Rreset & (committed < (3'd2 + 3'(xfer)));

    assign inflight_d = Pop;
    assign count_d    = count_q + CountWidth'(xfer);
    assign held_next  = (occ_next != '0) | inflight_d;
    assign full_next  = (3'(occ_next) + 3'(inflight_d)) == 3'd2;

    rd_skid_buf #(
        .DataSize (DataSize)
    ) u_buf (
        .clk_i      (Rclk),
        .rst_i      (Rreset),
        .wr_en_i    (inflight_q),
        .wr_data_i  (FifoData),
        .rd_en_i    (xfer),
        .flush_i    (Flush),
        .rd_data_o  (OutData),
        .occ_o      (occ),
        .occ_next_o (occ_next)
    );

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = Enable ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE:  if (Enable) state_d = RUN;
                RUN: begin
                    if (!Enable)        state_d = held_next ? DRAIN : IDLE;
                    else if (full_next) state_d = STALL;
                end
                STALL: if (xfer) state_d = RUN;
                DRAIN: begin
                    if (Enable)          state_d = RUN;
                    else if (!held_next) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Rclk or posedge Rreset) begin
        if (Rreset) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d & ~Flush;
            count_q    <= count_d;
        end
    end

    assign WordCount = count_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Randomised and directed bench for fifo_read_drainer against an ordered-stream model of the FIFO.
module tb_fifo_read_drainer;

    localparam int MAXW = 70000;

    logic        Rclk = 1'b0;
    logic        Rreset;
    logic        Enable;
    logic        Flush;
    logic        empty = 1'b1;
    logic [7:0]  FifoData = 8'd0;
    logic        Pop;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] WordCount;
    logic        Busy;

    fifo_read_drainer #(.DataSize(8), .CountWidth(16)) dut (
        .Rclk      (Rclk),
        .Rreset    (Rreset),
        .Enable    (Enable),
        .Flush     (Flush),
        .empty     (empty),
        .FifoData  (FifoData),
        .Pop       (Pop),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .WordCount (WordCount),
        .Busy      (Busy)
    );

    always #5 Rclk = ~Rclk;

    int checks = 0;
    int failures = 0;

    // Stream model: words[] in push order; popped words ahead of rd_idx; drops skip to drop_base.
    logic [7:0] words [MAXW];
    int wr_idx = 0;
    int rd_idx = 0;
    int drop_base = 0;
    int exp_idx = 0;
    int cyc = 0;
    int n_pops = 0;
    logic pop_last = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Rclk) begin
        cyc <= cyc + 1;
        pop_last <= Pop;
        if (Pop) begin
            check("pop_while_empty", int'(empty || (rd_idx >= wr_idx)), 0);
            FifoData <= words[rd_idx];
            rd_idx   <= rd_idx + 1;
            n_pops   <= n_pops + 1;
        end
        empty <= ((rd_idx + (Pop ? 1 : 0)) >= wr_idx);
        if (Flush || Rreset) drop_base <= rd_idx;
    end

    logic [15:0] wc_model = 16'd0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    int          m_base;
    int          m_outst;
    int          m_held;
    logic        m_xfer;
    logic        m_pop;

    always @(negedge Rclk) begin
        if (Rreset) begin
            wc_model   = 16'd0;
            prev_stall = 1'b0;
            check("reset_pop", int'(Pop), 0);
            check("reset_valid", int'(OutValid), 0);
        end else begin
            m_base  = (exp_idx < drop_base) ? drop_base : exp_idx;
            m_outst = rd_idx - m_base;
            m_held  = m_outst - (pop_last ? 1 : 0);
            m_xfer  = OutValid && OutReady;
            m_pop   = Enable && !empty && !Flush && ((m_outst - (m_xfer ? 1 : 0)) < 2);
            check("pop", int'(Pop), int'(m_pop));
            check("out_valid", int'(OutValid), int'((m_held > 0) && !Flush));
            check("word_count", int'(WordCount), int'(wc_model));
            if (prev_stall && !Flush) check("data_hold", int'(OutData), int'(prev_data));
            if (m_xfer) begin
                check("data", int'(OutData), (m_base < MAXW) ? int'(words[m_base]) : -1);
                exp_idx  = m_base + 1;
                wc_model = wc_model + 16'd1;
            end
            prev_stall = OutValid && !OutReady;
            prev_data  = OutData;
        end
    end

    task automatic tick();
        @(posedge Rclk);
        #1;
    endtask

    task automatic push(input int v);
        if (wr_idx < MAXW) begin
            words[wr_idx] = 8'(v);
            wr_idx++;
        end
    endtask

    function automatic bit drained();
        int b;
        b = (exp_idx < drop_base) ? drop_base : exp_idx;
        return (rd_idx == wr_idx) && (rd_idx == b) && !OutValid;
    endfunction

    task automatic wait_drain(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (drained()) break;
            tick();
        end
        check(name, int'(drained()), 1);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (!Busy) break;
            tick();
        end
        check(name, int'(Busy), 0);
    endtask

    int pop_c;
    int nv;
    int vc [3];
    int got [3];
    int pops0;

    initial begin
        Rreset = 1'b1; Enable = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        tick(); tick();
        check("rst_pop", int'(Pop), 0);
        check("rst_valid", int'(OutValid), 0);
        check("rst_data", int'(OutData), 0);
        check("rst_count", int'(WordCount), 0);
        check("rst_busy", int'(Busy), 0);
        Rreset = 1'b0;
        tick();

        // Three words, ready held high: latency and back-to-back delivery.
        push(10); push(20); push(30);
        Enable = 1'b1; OutReady = 1'b1;
        pop_c = -1; nv = 0;
        for (int i = 0; i < 20 && nv < 3; i++) begin
            @(negedge Rclk);
            if (Pop && pop_c < 0) pop_c = cyc;
            if (OutValid && OutReady) begin
                vc[nv] = cyc; got[nv] = int'(OutData); nv++;
            end
        end
        check("t1_words", nv, 3);
        check("t1_latency", vc[0] - pop_c, 2);
        check("t1_back2back_1", vc[1] - vc[0], 1);
        check("t1_back2back_2", vc[2] - vc[0], 2);
        check("t1_w0", got[0], 10);
        check("t1_w1", got[1], 20);
        check("t1_w2", got[2], 30);
        tick();
        check("t1_count", int'(WordCount), 3);
        Enable = 1'b0;
        wait_idle("t1_idle", 10);

        // Five words with ready low: exactly two pops, head held.
        for (int i = 0; i < 5; i++) push(41 + i);
        OutReady = 1'b0; Enable = 1'b1;
        pops0 = n_pops;
        for (int i = 0; i < 10; i++) tick();
        check("t2_pops", n_pops - pops0, 2);
        check("t2_busy", int'(Busy), 1);
        check("t2_valid", int'(OutValid), 1);
        check("t2_head", int'(OutData), 41);
        OutReady = 1'b1;
        wait_drain("t2_drain", 40);
        check("t2_count", int'(WordCount), 8);
        Enable = 1'b0;
        wait_idle("t2_idle", 10);

        // Flush with a full buffer: two held words dropped, count unchanged.
        for (int i = 0; i < 5; i++) push(51 + i);
        OutReady = 1'b0; Enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        Flush = 1'b1;
        @(negedge Rclk);
        check("t3_valid_flush", int'(OutValid), 0);
        tick();
        Flush = 1'b0;
        @(negedge Rclk);
        check("t3_valid_after", int'(OutValid), 0);
        check("t3_count_kept", int'(WordCount), 8);
        check("t3_dropped", drop_base - exp_idx, 2);
        tick();
        OutReady = 1'b1;
        wait_drain("t3_drain", 40);
        check("t3_count", int'(WordCount), 11);

        // Flush mid-stream with ready high: one held plus one in flight.
        for (int i = 0; i < 6; i++) push(61 + i);
        for (int i = 0; i < 4; i++) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        wait_drain("t3b_drain", 40);
        Enable = 1'b0;
        wait_idle("t3b_idle", 10);

        // Enable dropped mid-burst: held and in-flight words finish, rest stays queued.
        for (int i = 0; i < 6; i++) push(71 + i);
        Enable = 1'b1; OutReady = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        Enable = 1'b0;
        pops0 = n_pops;
        for (int i = 0; i < 8; i++) tick();
        check("t4_no_pop", n_pops - pops0, 0);
        wait_idle("t4_idle", 10);
        check("t4_flushed_out", rd_idx - exp_idx, 0);
        check("t4_left_in_fifo", int'((wr_idx - rd_idx) > 0), 1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            Enable   = ($urandom % 8) != 0;
            OutReady = ($urandom % 3) != 0;
            Flush    = ($urandom % 40) == 0;
            if (($urandom % 4) == 0) push(int'($urandom % 256));
            tick();
        end
        Flush = 1'b0; Enable = 1'b1; OutReady = 1'b1;
        wait_drain("t5_drain", 300);
        Enable = 1'b0;
        wait_idle("t5_idle", 10);

        // Asynchronous reset between edges with data valid.
        for (int i = 0; i < 4; i++) push(81 + i);
        OutReady = 1'b0; Enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("t6_valid_pre", int'(OutValid), 1);
        @(posedge Rclk);
        #3 Rreset = 1'b1;
        #1;
        check("t6_pop", int'(Pop), 0);
        check("t6_valid", int'(OutValid), 0);
        check("t6_data", int'(OutData), 0);
        check("t6_count", int'(WordCount), 0);
        check("t6_busy", int'(Busy), 0);
        tick(); tick();
        Rreset = 1'b0;
        OutReady = 1'b1;
        wait_drain("t6_drain", 40);
        check("t6_count_after", int'(WordCount), 2);
        Enable = 1'b0;
        wait_idle("t6_idle", 10);

        // Counter wrap: 65535 more transfers from 2 leaves the counter at 1.
        for (int i = 0; i < 65535; i++) push(i % 256);
        Enable = 1'b1; OutReady = 1'b1;
        wait_drain("t7_drain", 66000);
        check("t7_wrap", int'(WordCount), 1);
        Enable = 1'b0;
        wait_idle("t7_idle", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
